// File: rtl/writeback_unit.sv
// Registered N-lane writeback stage with in-order trap resolution and a RUN/TRAP stall FSM.
// Optional retire counter on port retire_cnt_o is enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int LW    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  input  logic [LANES-1:0]        lane_en_i,
  input  logic [LANES*XLEN-1:0]   alu_out_i,
  input  logic [LANES*XLEN-1:0]   load_data_i,
  input  logic [LANES*XLEN-1:0]   pc_i,
  input  logic [LANES*RA_W-1:0]   rd_addr_i,
  input  logic [LANES-1:0]        regwrite_i,
  input  logic [LANES*2-1:0]      wb_sel_i,
  input  logic [LANES*2-1:0]      ld_size_i,
  input  logic [LANES-1:0]        ld_unsigned_i,
  input  logic [LANES*2-1:0]      ld_off_i,
  input  logic [LANES-1:0]        illegal_i,
  input  logic [LANES-1:0]        misaligned_i,
  input  logic                    trap_ack_i,
  output logic [LANES-1:0]        rd_we_o,
  output logic [LANES*RA_W-1:0]   rd_addr_o,
  output logic [LANES*XLEN-1:0]   rd_data_o,
  output logic                    trap_o,
  output logic [LW-1:0]           trap_lane_o,
  output logic [XLEN-1:0]         trap_pc_o,
  output logic [1:0]              trap_cause_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]             retire_cnt_o
`endif
);

  typedef enum logic {RUN, TRAP} state_e;

  state_e                  state_q, state_d;
  logic [LANES-1:0]        rd_we_q, rd_we_d;
  logic [LANES*RA_W-1:0]   rd_addr_q, rd_addr_d;
  logic [LANES*XLEN-1:0]   rd_data_q, rd_data_d;
  logic                    trap_q, trap_d;
  logic [LW-1:0]           trap_lane_q, trap_lane_d;
  logic [XLEN-1:0]         trap_pc_q, trap_pc_d;
  logic [1:0]              trap_cause_q, trap_cause_d;
  logic                    accept;
  logic                    squash;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]             cnt_q, cnt_d;
  logic [2:0]              retired;
`endif

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] w,
                                               input logic [1:0] sz,
                                               input logic [1:0] off,
                                               input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    if (sz[1])
      return w;
    else if (!sz[0])
      return {{(XLEN-8){b[7] & ~uns}}, b};
    else
      return {{(XLEN-16){h[15] & ~uns}}, h};
  endfunction

  function automatic logic [XLEN-1:0] lane_result(input logic [1:0] sel,
                                                  input logic [XLEN-1:0] alu,
                                                  input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] ld);
    case (sel)
      2'b01:   return pc + XLEN'(4);
      2'b10:   return ld;
      default: return alu;
    endcase
  endfunction

  assign accept = (state_q == RUN) & valid_i & ~flush_i;

  always_comb begin
    state_d      = state_q;
    rd_we_d      = '0;
    rd_addr_d    = '0;
    rd_data_d    = '0;
    trap_d       = trap_q;
    trap_lane_d  = trap_lane_q;
    trap_pc_d    = trap_pc_q;
    trap_cause_d = trap_cause_q;
    squash       = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    cnt_d        = cnt_q;
    retired      = '0;
`endif
    case (state_q)
      RUN: begin
        if (accept) begin
          // Walk lanes oldest-first; the first fault squashes itself and every younger lane.
          for (int unsigned k = 0; k < LANES; k++) begin
            if (!squash && lane_en_i[k] && (illegal_i[k] || misaligned_i[k])) begin
              squash       = 1'b1;
              state_d      = TRAP;
              trap_d       = 1'b1;
              trap_lane_d  = LW'(k);
              trap_pc_d    = pc_i[k*XLEN +: XLEN];
              trap_cause_d = illegal_i[k] ? 2'd1 : 2'd2;
            end
            if (!squash && lane_en_i[k]) begin
`ifdef WB_RETIRE_CNT_EN
              retired = retired + 3'd1;
`endif
              if (regwrite_i[k] && (rd_addr_i[k*RA_W +: RA_W] != '0)) begin
                rd_we_d[k]                  = 1'b1;
                rd_addr_d[k*RA_W +: RA_W]   = rd_addr_i[k*RA_W +: RA_W];
                rd_data_d[k*XLEN +: XLEN]   = lane_result(
                    wb_sel_i[k*2 +: 2], alu_out_i[k*XLEN +: XLEN], pc_i[k*XLEN +: XLEN],
                    load_ext(load_data_i[k*XLEN +: XLEN], ld_size_i[k*2 +: 2],
                             ld_off_i[k*2 +: 2], ld_unsigned_i[k]));
              end
            end
          end
`ifdef WB_RETIRE_CNT_EN
          cnt_d = cnt_q + 64'(retired);
`endif
        end
      end
      TRAP: begin
        if (trap_ack_i) begin
          state_d      = RUN;
          trap_d       = 1'b0;
          trap_lane_d  = '0;
          trap_pc_d    = '0;
          trap_cause_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= RUN;
      rd_we_q      <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      trap_q       <= 1'b0;
      trap_lane_q  <= '0;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
`ifdef WB_RETIRE_CNT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_we_q      <= rd_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      trap_q       <= trap_d;
      trap_lane_q  <= trap_lane_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
`ifdef WB_RETIRE_CNT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ready_o      = (state_q == RUN);
  assign rd_we_o      = rd_we_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign trap_o       = trap_q;
  assign trap_lane_o  = trap_lane_q;
  assign trap_pc_o    = trap_pc_q;
  assign trap_cause_o = trap_cause_q;
`ifdef WB_RETIRE_CNT_EN
  assign retire_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit (LANES=2): directed cases then randomized groups.
module tb_writeback_unit;
  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int LW    = 1;

  logic clk = 1'b0;
  logic rst_n_i;
  always #5 clk = ~clk;

  logic                  v, fl, ack;
  logic [LANES-1:0]      en, rw, uns, ill, mis;
  logic [LANES*XLEN-1:0] alu, ld, pc;
  logic [LANES*RA_W-1:0] rd;
  logic [LANES*2-1:0]    sel, sz, off;

  logic                  ready_o, trap_o;
  logic [LANES-1:0]      rd_we_o;
  logic [LANES*RA_W-1:0] rd_addr_o;
  logic [LANES*XLEN-1:0] rd_data_o;
  logic [LW-1:0]         trap_lane_o;
  logic [XLEN-1:0]       trap_pc_o;
  logic [1:0]            trap_cause_o;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]           retire_cnt_o;
  logic [63:0]           model_cnt = '0;
`endif

  writeback_unit #(.LANES(LANES), .XLEN(XLEN), .RA_W(RA_W), .LW(LW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(v), .ready_o(ready_o), .flush_i(fl),
    .lane_en_i(en), .alu_out_i(alu), .load_data_i(ld), .pc_i(pc), .rd_addr_i(rd),
    .regwrite_i(rw), .wb_sel_i(sel), .ld_size_i(sz), .ld_unsigned_i(uns), .ld_off_i(off),
    .illegal_i(ill), .misaligned_i(mis), .trap_ack_i(ack),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .trap_o(trap_o),
    .trap_lane_o(trap_lane_o), .trap_pc_o(trap_pc_o), .trap_cause_o(trap_cause_o)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt_o(retire_cnt_o)
`endif
  );

  typedef struct {
    logic [LANES-1:0]      we;
    logic [LANES*XLEN-1:0] data;
    logic [LANES*RA_W-1:0] addr;
    bit                    trap;
    logic [LW-1:0]         lane;
    logic [XLEN-1:0]       tpc;
    logic [1:0]            cause;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   pending = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lane value from the selection/extension rules, in plain arithmetic.
  function automatic logic [31:0] ref_res(input int k);
    logic [31:0] w, r;
    int o;
    w = ld[k*32 +: 32];
    o = int'(off[k*2 +: 2]);
    case (sel[k*2 +: 2])
      2'd1: r = pc[k*32 +: 32] + 32'd4;
      2'd2: begin
        if (sz[k*2+1]) r = w;
        else if (!sz[k*2]) begin
          r = (w >> (8 * o)) & 32'hFF;
          if (!uns[k] && (r >= 32'h80)) r = r | 32'hFFFF_FF00;
        end else begin
          r = (w >> (16 * (o / 2))) & 32'hFFFF;
          if (!uns[k] && (r >= 32'h8000)) r = r | 32'hFFFF_0000;
        end
      end
      default: r = alu[k*32 +: 32];
    endcase
    return r;
  endfunction

  task automatic idle_stim();
    v = 0; fl = 0; ack = 0; en = '0; rw = '0; uns = '0; ill = '0; mis = '0;
    alu = '0; ld = '0; pc = '0; rd = '0; sel = '0; sz = '0; off = '0;
  endtask

  // Applies current stimulus for one cycle; model predicts and pushes after the edge.
  task automatic step();
    exp_t e;
    bit   acc, has, nxt;
    int   fk, nret;
    e = '{we: '0, data: '0, addr: '0, trap: 0, lane: '0, tpc: '0, cause: '0};
    acc = v && !fl && !pending;
    fk = LANES;
    nret = 0;
    if (acc) begin
      for (int k = 0; k < LANES; k++)
        if (fk == LANES && en[k] && (ill[k] || mis[k])) fk = k;
      for (int k = 0; k < fk; k++) begin
        if (en[k]) nret++;
        if (en[k] && rw[k] && rd[k*RA_W +: RA_W] != 0) begin
          e.we[k] = 1'b1;
          e.addr[k*RA_W +: RA_W] = rd[k*RA_W +: RA_W];
          e.data[k*XLEN +: XLEN] = ref_res(k);
        end
      end
      if (fk < LANES) begin
        e.trap  = 1;
        e.lane  = LW'(fk);
        e.tpc   = pc[fk*XLEN +: XLEN];
        e.cause = ill[fk] ? 2'd1 : 2'd2;
      end
    end
    has = acc && (e.we != 0 || e.trap);
    nxt = pending ? !ack : (acc && e.trap);
    @(posedge clk);
    #1;
    if (has) sbq.push_back(e);
    pending = nxt;
`ifdef WB_RETIRE_CNT_EN
    model_cnt = model_cnt + 64'(nret);
    chk("retire_cnt", retire_cnt_o, model_cnt);
`endif
    chk("ready", {63'd0, ready_o}, {63'd0, !pending});
    chk("trap_state", {63'd0, trap_o}, {63'd0, pending});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 64'(rd_we_o), 64'd0);
    chk({tag, "_data"}, 64'(rd_data_o), 64'd0);
    chk({tag, "_addr"}, 64'(rd_addr_o), 64'd0);
    chk({tag, "_trap"}, 64'(trap_o), 64'd0);
    chk({tag, "_tlane"}, 64'(trap_lane_o), 64'd0);
    chk({tag, "_tpc"}, 64'(trap_pc_o), 64'd0);
    chk({tag, "_tcause"}, 64'(trap_cause_o), 64'd0);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
  endtask

  // Monitor: every output event must match the oldest expectation, and vice versa.
  bit            trap_prev = 0;
  logic [LW-1:0] h_lane;
  logic [31:0]   h_pc;
  logic [1:0]    h_cause;
  always @(negedge clk) begin
    exp_t e;
    logic [LANES*RA_W-1:0] m;
    bit present;
    present = (rd_we_o != 0) || (trap_o && !trap_prev);
    if (trap_o && trap_prev) begin
      chk("trap_hold_lane", 64'(trap_lane_o), 64'(h_lane));
      chk("trap_hold_pc", 64'(trap_pc_o), 64'(h_pc));
      chk("trap_hold_cause", 64'(trap_cause_o), 64'(h_cause));
    end
    if (present && sbq.size() == 0) begin
      chk("spurious_we", 64'(rd_we_o), 64'd0);
      chk("spurious_trap", 64'(trap_o && !trap_prev), 64'd0);
    end else if (sbq.size() != 0) begin
      e = sbq.pop_front();
      m = '0;
      for (int k = 0; k < LANES; k++) if (e.we[k]) m[k*RA_W +: RA_W] = '1;
      chk("rd_we", 64'(rd_we_o), 64'(e.we));
      chk("rd_data", 64'(rd_data_o), 64'(e.data));
      chk("rd_addr", 64'(rd_addr_o & m), 64'(e.addr));
      chk("trap_rise", 64'(trap_o && !trap_prev), 64'(e.trap));
      if (e.trap) begin
        chk("trap_lane", 64'(trap_lane_o), 64'(e.lane));
        chk("trap_pc", 64'(trap_pc_o), 64'(e.tpc));
        chk("trap_cause", 64'(trap_cause_o), 64'(e.cause));
        h_lane = e.lane; h_pc = e.tpc; h_cause = e.cause;
      end
    end
    trap_prev = trap_o;
  end

  initial begin
    idle_stim();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    repeat (3) step();

    // Both lanes ALU, rd 3/4.
    v = 1; en = 2'b11; rw = 2'b11; rd = {5'd4, 5'd3};
    alu = {32'h22, 32'h11};
    step();
    idle_stim(); step(); step();

    // Byte load, offset 3, signed then unsigned.
    v = 1; en = 2'b01; rw = 2'b01; rd = {5'd0, 5'd5}; sel = 2'b10; sz = 2'b00; off = 2'b11;
    ld = {32'h0, 32'h80FF_0000};
    step();
    uns = 2'b01; step();
    // Half loads from upper and lower halves, signed.
    uns = 2'b00; sz = 2'b01; off = 2'b10; ld = {32'h0, 32'h8123_7FFF}; step();
    off = 2'b01; step();
    idle_stim(); step();

    // Lane1 illegal: lane0 retires, trap on lane1.
    v = 1; en = 2'b11; rw = 2'b11; rd = {5'd7, 5'd6}; alu = {32'h77, 32'h66};
    pc = {32'h104, 32'h100}; ill = 2'b10;
    step();
    ill = 2'b00; step(); step();
    idle_stim(); step();
    ack = 1; step();
    idle_stim(); step();

    // Lane0 illegal and misaligned; lane1 write squashed.
    v = 1; en = 2'b11; rw = 2'b11; rd = {5'd9, 5'd8}; pc = {32'h204, 32'h200};
    ill = 2'b01; mis = 2'b01;
    step();
    idle_stim(); ack = 1; step();
    // Lane1 misaligned only.
    v = 1; en = 2'b11; rw = 2'b11; rd = {5'd9, 5'd8}; pc = {32'h304, 32'h300}; mis = 2'b10;
    step();
    idle_stim(); ack = 1; step();

    // PC+4 wrap, x0 suppression, flush.
    v = 1; en = 2'b11; rw = 2'b11; sel = 2'b01; rd = {5'd0, 5'd10};
    pc = {32'h10, 32'hFFFF_FFFC};
    step();
    fl = 1; rd = {5'd11, 5'd10}; ill = 2'b01; step();
    idle_stim(); step(); step();

    // Reset while in TRAP.
    v = 1; en = 2'b01; pc = {32'h0, 32'h400}; ill = 2'b01;
    step();
    idle_stim();
    @(negedge clk);
    #1;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    pending = 0;
`ifdef WB_RETIRE_CNT_EN
    model_cnt = '0;
`endif
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    step();

    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 2) == 0);
      en  = LANES'($urandom);
      rw  = LANES'($urandom);
      uns = LANES'($urandom);
      sel = 4'($urandom);
      sz  = 4'($urandom);
      off = 4'($urandom);
      rd  = 10'($urandom);
      alu = {$urandom, $urandom};
      ld  = {$urandom, $urandom};
      pc  = {$urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom};
      for (int k = 0; k < LANES; k++) begin
        ill[k] = ($urandom_range(0, 9) == 0);
        mis[k] = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    idle_stim();
    ack = 1;
    step(); step();
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
